axi4lite_master_bridge: RTL and testbench

- Initiator (master) end of the AXI4-Lite register interface used by our generated register blocks.
- Converts a simple single-outstanding request/response bus from a local controller (sequencer, CPU-less init FSM, debug port) into AXI4-Lite read and write transactions.
- Returns the read data, a response-error flag and a timeout flag.
- Exactly one transaction is in flight at any time.

---
 rtl/axi4lite_master_bridge_if.sv | 54 +++++
 rtl/axi4lite_master_bridge.sv | 139 +++++++++++++
 tb/tb_axi4lite_master_bridge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_master_bridge_if.sv
// Local request/response bus plus AXI4-Lite master channels for the bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface axi4lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp,
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp,
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding local request bus to AXI4-Lite master, with optional
// transaction timeout. Every output is a register.
module axi4lite_master_bridge #(
  parameter int         ADDR_WIDTH = 5,
  parameter int         TIMEOUT    = 255,
  parameter logic [2:0] PROT       = 3'b000
) (
  input logic                      aclk,
  input logic                      areset,
  axi4lite_master_bridge_if.master bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_req_ready, r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [31:0]           r_rsp_rdata;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  w_hs_b, w_hs_r, w_expire;

  assign w_hs_b   = bus.bvalid & r_bready;
  assign w_hs_r   = bus.rvalid & r_rready;
  // Fires on the cycle the counter would reach TIMEOUT; a B/R handshake in that cycle wins.
  assign w_expire = (TIMEOUT != 0) && (r_cnt == LAST);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            if (bus.req_write) begin
              r_state   <= WRITE;
              r_awaddr  <= bus.req_addr;
              r_wdata   <= bus.req_wdata;
              r_wstrb   <= bus.req_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
            end else begin
              r_state   <= READ;
              r_araddr  <= bus.req_addr;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end
        end
        WRITE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_awvalid && bus.awready) r_awvalid <= 1'b0;
          if (r_wvalid && bus.wready)   r_wvalid  <= 1'b0;
          if (w_hs_b) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_bready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= (bus.bresp != 2'b00);
          end else if (w_expire) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_bready      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end
        end
        READ: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_arvalid && bus.arready) r_arvalid <= 1'b0;
          if (w_hs_r) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.rdata;
            r_rsp_err   <= (bus.rresp != 2'b00);
          end else if (w_expire) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_rready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.awvalid     = r_awvalid;
  assign bus.awaddr      = r_awaddr;
  assign bus.awprot      = PROT;
  assign bus.wvalid      = r_wvalid;
  assign bus.wdata       = r_wdata;
  assign bus.wstrb       = r_wstrb;
  assign bus.bready      = r_bready;
  assign bus.arvalid     = r_arvalid;
  assign bus.araddr      = r_araddr;
  assign bus.arprot      = PROT;
  assign bus.rready      = r_rready;
endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed and randomized checks of the AXI4-Lite master bridge against a
// word-array register model and a configurable wait-state slave.
module tb_axi4lite_master_bridge;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4lite_master_bridge_if #(.ADDR_WIDTH(5)) bus();
  axi4lite_master_bridge #(.ADDR_WIDTH(5), .TIMEOUT(8), .PROT(3'b101)) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  int checks = 0, failures = 0;
  // slave knobs
  int cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic cfg_ar_never = 1'b0, late_r = 1'b0;
  // reference register model
  logic [31:0] mem_model [8];
  // per-transaction observations
  int n_aw, n_w, n_ar, lat;
  logic aw_unstable, rdy_at_rsp;
  logic [31:0] o_rd;
  logic o_er, o_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_model[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Slave: decides its inputs at each negedge from what it drove and saw last negedge.
  initial begin : slave
    logic [31:0] slv_mem [8];
    logic got_aw, got_w, b_pend, r_pend, late_on;
    logic p_aw, p_w, p_b, p_ar, p_r;
    logic [4:0] p_awaddr, p_araddr, s_awaddr, s_araddr;
    logic [31:0] p_wdata, s_wdata;
    logic [3:0] p_wstrb, s_wstrb;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    for (int i = 0; i < 8; i++) slv_mem[i] = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    {got_aw, got_w, b_pend, r_pend, late_on, p_aw, p_w, p_b, p_ar, p_r} = '0;
    {p_awaddr, p_araddr, s_awaddr, s_araddr, p_wdata, s_wdata, p_wstrb, s_wstrb} = '0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        {got_aw, got_w, b_pend, r_pend, late_on, p_aw, p_w, p_b, p_ar, p_r} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
      end else begin
        if (p_aw && bus.awready) begin got_aw = 1; s_awaddr = p_awaddr; bus.awready = 0; aw_cnt = 0; end
        if (p_w && bus.wready) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; bus.wready = 0; w_cnt = 0; end
        if (bus.bvalid && p_b) bus.bvalid = 0;
        if (p_ar && bus.arready) begin bus.arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; s_araddr = p_araddr; end
        if (bus.rvalid && p_r) bus.rvalid = 0;
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) slv_mem[s_awaddr[4:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
          got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (b_pend) begin
          if (b_cnt >= cfg_b_wait) begin bus.bvalid = 1; bus.bresp = cfg_bresp; b_pend = 0; end
          else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= cfg_r_wait) begin
            bus.rvalid = 1; bus.rdata = slv_mem[s_araddr[4:2]]; bus.rresp = cfg_rresp; r_pend = 0;
          end else r_cnt++;
        end
        if (late_r) begin bus.rvalid = 1; bus.rdata = 32'hBAD0BAD0; late_on = 1; end
        else if (late_on) begin bus.rvalid = 0; late_on = 0; end
        if (bus.awvalid && !bus.awready && !got_aw) begin
          if (aw_cnt >= cfg_aw_wait) bus.awready = 1; else aw_cnt++;
        end
        if (bus.wvalid && !bus.wready && !got_w) begin
          if (w_cnt >= cfg_w_wait) bus.wready = 1; else w_cnt++;
        end
        if (bus.arvalid && !bus.arready && !r_pend && !cfg_ar_never) begin
          if (ar_cnt >= cfg_ar_wait) bus.arready = 1; else ar_cnt++;
        end
        p_aw = bus.awvalid; p_w = bus.wvalid; p_b = bus.bready; p_ar = bus.arvalid; p_r = bus.rready;
        p_awaddr = bus.awaddr; p_wdata = bus.wdata; p_wstrb = bus.wstrb; p_araddr = bus.araddr;
      end
    end
  end

  // Called at a negedge with the bridge idle; returns at the negedge of cycle 1.
  task automatic start_req(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
    @(negedge aclk);
    bus.req_valid = 0;
    chk("req_ready_busy", bus.req_ready, 0);
  endtask

  // Returns at the negedge of the rsp_valid cycle; lat is the cycle index after accept.
  task automatic wait_rsp();
    logic [4:0] a0;
    int n;
    n = 1; n_aw = 0; n_w = 0; n_ar = 0; aw_unstable = 0; a0 = bus.awaddr;
    while (!bus.rsp_valid && n < 60) begin
      if (bus.awvalid) begin n_aw++; if (bus.awaddr !== a0) aw_unstable = 1; end
      if (bus.wvalid) n_w++;
      if (bus.arvalid) n_ar++;
      @(negedge aclk);
      n++;
    end
    chk("rsp_arrived", bus.rsp_valid, 1);
    lat = n; o_rd = bus.rsp_rdata; o_er = bus.rsp_err; o_to = bus.rsp_timeout; rdy_at_rsp = bus.req_ready;
  endtask

  task automatic chk_single_pulse(input string tag);
    @(negedge aclk);
    chk(tag, bus.rsp_valid, 0);
  endtask

  initial begin : main
    logic wr;
    logic [4:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [1:0] resp;
    for (int i = 0; i < 8; i++) mem_model[i] = '0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
    repeat (3) @(negedge aclk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_addr_data", {bus.awaddr, bus.araddr, bus.wstrb}, 0);
    chk("rst_wdata", bus.wdata, 0);
    areset = 0;
    @(negedge aclk);

    // zero-wait write
    start_req(1, 5'h14, 32'hDEADBEEF, 4'hF);
    chk("zw_aw_w_valid", {bus.awvalid, bus.wvalid, bus.bready}, 3'b111);
    chk("zw_awaddr", bus.awaddr, 5'h14);
    chk("zw_wdata", bus.wdata, 32'hDEADBEEF);
    chk("zw_wstrb", bus.wstrb, 4'hF);
    chk("zw_awprot", bus.awprot, 3'b101);
    wait_rsp();
    model_write(5'h14, 32'hDEADBEEF, 4'hF);
    chk("zw_latency", lat, 3);
    chk("zw_err_to", {o_er, o_to}, 0);
    chk("zw_rdata", o_rd, 0);
    chk_single_pulse("zw_single");

    // skewed write: AW held off 4 cycles, W immediate
    cfg_aw_wait = 4;
    start_req(1, 5'h08, 32'hCAFEF00D, 4'b0101);
    wait_rsp();
    model_write(5'h08, 32'hCAFEF00D, 4'b0101);
    chk("sk_aw_cycles", n_aw, 5);
    chk("sk_w_cycles", n_w, 1);
    chk("sk_awaddr_stable", aw_unstable, 0);
    chk("sk_latency", lat, 7);
    chk("sk_err", o_er, 0);
    chk_single_pulse("sk_single");
    cfg_aw_wait = 0;

    // error read after three wait cycles
    start_req(1, 5'h10, 32'h0000000A, 4'hF);
    wait_rsp();
    model_write(5'h10, 32'h0000000A, 4'hF);
    @(negedge aclk);
    cfg_r_wait = 3; cfg_rresp = 2'b10;
    start_req(0, 5'h10, 32'h0, 4'h0);
    chk("er_arprot", bus.arprot, 3'b101);
    chk("er_araddr", bus.araddr, 5'h10);
    wait_rsp();
    chk("er_rdata", o_rd, mem_model[4]);
    chk("er_err", o_er, 1);
    chk("er_ready_same_cycle", rdy_at_rsp, 1);
    chk("er_latency", lat, 6);
    chk_single_pulse("er_single");
    cfg_r_wait = 0; cfg_rresp = 2'b00;

    // timeout: arready never comes
    cfg_ar_never = 1;
    start_req(0, 5'h04, 32'h0, 4'h0);
    wait_rsp();
    chk("to_ar_cycles", n_ar, 8);
    chk("to_latency", lat, 9);
    chk("to_flags", {o_to, o_er}, 2'b10);
    chk("to_rdata", o_rd, 0);
    chk("to_dropped", {bus.arvalid, bus.rready}, 0);
    cfg_ar_never = 0; late_r = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("to_late_r_ignored", {bus.rsp_valid, bus.req_ready}, 2'b01);
    end
    late_r = 0;
    @(negedge aclk);

    // back-to-back write then read presented in the rsp_valid cycle
    start_req(1, 5'h00, 32'h12345678, 4'hF);
    wait_rsp();
    model_write(5'h00, 32'h12345678, 4'hF);
    chk("bb_w_latency", lat, 3);
    start_req(0, 5'h00, 32'h0, 4'h0);
    wait_rsp();
    chk("bb_r_latency", lat, 3);
    chk("bb_rdata", o_rd, 32'h12345678);
    chk_single_pulse("bb_single");

    // reset mid-write
    cfg_aw_wait = 50;
    start_req(1, 5'h0C, 32'h55AA55AA, 4'hF);
    @(negedge aclk);
    chk("mr_aw_pending", bus.awvalid, 1);
    areset = 1;
    @(negedge aclk);
    chk("mr_valids_drop", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    chk("mr_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);
    @(negedge aclk);
    areset = 0; cfg_aw_wait = 0;
    @(negedge aclk);
    chk("mr_no_rsp", bus.rsp_valid, 0);
    start_req(1, 5'h0C, 32'h0BADF00D, 4'hF);
    wait_rsp();
    model_write(5'h0C, 32'h0BADF00D, 4'hF);
    chk("mr_w_latency", lat, 3);
    chk("mr_w_err", {o_er, o_to}, 0);
    @(negedge aclk);

    // randomized traffic against the register model
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(1)); a = 5'($urandom); d = $urandom; s = 4'($urandom);
      resp = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      cfg_aw_wait = $urandom_range(2); cfg_w_wait = $urandom_range(2); cfg_b_wait = $urandom_range(2);
      cfg_ar_wait = $urandom_range(2); cfg_r_wait = $urandom_range(2);
      cfg_bresp = resp; cfg_rresp = resp;
      start_req(wr, a, d, s);
      wait_rsp();
      if (wr) model_write(a, d, s);
      chk("rnd_rdata", o_rd, wr ? 32'h0 : mem_model[a[4:2]]);
      chk("rnd_err", o_er, resp != 2'b00);
      chk("rnd_timeout", o_to, 0);
      if ($urandom_range(1) == 0) @(negedge aclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
